// File: rtl/bcd_operand_entry_pkg.sv
// Shared constants for the BCD calculator operand-entry stage.
package bcd_operand_entry_pkg;

  localparam int ST_W = 3;

  typedef enum logic [ST_W-1:0] {
    L_HI = 3'd0,
    L_LO = 3'd1,
    R_HI = 3'd2,
    R_LO = 3'd3,
    DONE = 3'd4
  } entry_state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic       KEY_UP  = 1'b1;

endpackage

// File: rtl/bcd_operand_entry_key_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter, and a
// registered one-cycle pulse on each debounced press (1 -> 0).
module key_debounce
  import bcd_operand_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic CLOCK_50,
  input  logic RST_N,
  input  logic key_n,
  output logic press_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_meta;
  logic             sync_key;
  logic             level;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      sync_meta   <= KEY_UP;
      sync_key    <= KEY_UP;
      level       <= KEY_UP;
      cnt         <= '0;
      press_pulse <= 1'b0;
    end else begin
      sync_meta   <= key_n;
      sync_key    <= sync_meta;
      press_pulse <= 1'b0;
      if (sync_key == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
        level       <= sync_key;
        cnt         <= '0;
        press_pulse <= (sync_key != KEY_UP);
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/bcd_operand_entry.sv
// Collects two 2-digit BCD operands digit by digit from switches and a button.
// Handshake: OUT_VALID rises with the last digit and holds, with operands frozen,
// until an edge where OUT_VALID & OUT_READY; OUT_READY is ignored while OUT_VALID = 0.
module bcd_operand_entry
  import bcd_operand_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic            CLOCK_50,
  input  logic            RST_N,
  input  logic            KEY_ENTER,
  input  logic            KEY_CLEAR,
  input  logic [3:0]      DIGIT,
  input  logic            OP_SUB,
  input  logic            OUT_READY,
  output logic [7:0]      LEFT_BCD,
  output logic [7:0]      RIGHT_BCD,
  output logic            SUB_MODE,
  output logic            OUT_VALID,
  output logic [ST_W-1:0] ENTRY_STATE,
  output logic            DIGIT_ERR
);

  logic         enter_pulse;
  logic         clear_pulse;
  logic         digit_ok;
  entry_state_e state;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter_key (
    .CLOCK_50   (CLOCK_50),
    .RST_N      (RST_N),
    .key_n      (KEY_ENTER),
    .press_pulse(enter_pulse)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_key (
    .CLOCK_50   (CLOCK_50),
    .RST_N      (RST_N),
    .key_n      (KEY_CLEAR),
    .press_pulse(clear_pulse)
  );

  assign digit_ok    = (DIGIT <= BCD_MAX);
  assign ENTRY_STATE = state;

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      state     <= L_HI;
      LEFT_BCD  <= 8'h00;
      RIGHT_BCD <= 8'h00;
      SUB_MODE  <= 1'b0;
      OUT_VALID <= 1'b0;
      DIGIT_ERR <= 1'b0;
    end else if (clear_pulse) begin
      // Clear dominates a coincident enter; a coincident transfer is simply absorbed.
      state     <= L_HI;
      LEFT_BCD  <= 8'h00;
      RIGHT_BCD <= 8'h00;
      SUB_MODE  <= 1'b0;
      OUT_VALID <= 1'b0;
      DIGIT_ERR <= 1'b0;
    end else begin
      case (state)
        L_HI, L_LO, R_HI, R_LO: begin
          if (enter_pulse && !digit_ok) begin
            DIGIT_ERR <= 1'b1;
          end else if (enter_pulse) begin
            DIGIT_ERR <= 1'b0;
            case (state)
              L_HI:    begin LEFT_BCD[7:4]  <= DIGIT; state <= L_LO; end
              L_LO:    begin LEFT_BCD[3:0]  <= DIGIT; state <= R_HI; end
              R_HI:    begin RIGHT_BCD[7:4] <= DIGIT; state <= R_LO; end
              default: begin
                RIGHT_BCD[3:0] <= DIGIT;
                SUB_MODE       <= OP_SUB;
                OUT_VALID      <= 1'b1;
                state          <= DONE;
              end
            endcase
          end
        end
        DONE: begin
          if (OUT_READY) begin
            OUT_VALID <= 1'b0;
            state     <= L_HI;
          end
        end
        default: begin
          OUT_VALID <= 1'b0;
          state     <= L_HI;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_operand_entry.sv
// Directed bench for bcd_operand_entry with DEBOUNCE_CYCLES = 4.
module tb_bcd_operand_entry;
  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_enter;
  logic       key_clear;
  logic [3:0] digit;
  logic       op_sub;
  logic       out_ready;
  logic [7:0] left_bcd;
  logic [7:0] right_bcd;
  logic       sub_mode;
  logic       out_valid;
  logic [2:0] entry_state;
  logic       digit_err;

  int n_checks = 0;
  int n_pass   = 0;

  bcd_operand_entry #(.DEBOUNCE_CYCLES(DB)) dut (
    .CLOCK_50   (clk),
    .RST_N      (rst_n),
    .KEY_ENTER  (key_enter),
    .KEY_CLEAR  (key_clear),
    .DIGIT      (digit),
    .OP_SUB     (op_sub),
    .OUT_READY  (out_ready),
    .LEFT_BCD   (left_bcd),
    .RIGHT_BCD  (right_bcd),
    .SUB_MODE   (sub_mode),
    .OUT_VALID  (out_valid),
    .ENTRY_STATE(entry_state),
    .DIGIT_ERR  (digit_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] digit;
    logic       op;
    logic [7:0] left;
    logic [7:0] right;
    logic [2:0] st;
    logic       err;
    logic       valid;
    logic       sub;
  } vec_t;

  vec_t vecs[5];

  // drivers
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [3:0] d, input logic op, input logic use_enter,
                       input logic use_clear);
    digit = d;
    op_sub = op;
    if (use_enter) key_enter = 1'b0;
    if (use_clear) key_clear = 1'b0;
    step(DB + 4);
    key_enter = 1'b1;
    key_clear = 1'b1;
    step(DB + 4);
  endtask

  // scoreboard
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_all(input string tag, input logic [7:0] l, input logic [7:0] r,
                           input logic [2:0] st, input logic err, input logic v,
                           input logic s);
    check({tag, " left"},  {8'h00, left_bcd},  {8'h00, l});
    check({tag, " right"}, {8'h00, right_bcd}, {8'h00, r});
    check({tag, " state"}, {13'h0, entry_state}, {13'h0, st});
    check({tag, " err"},   {15'h0, digit_err}, {15'h0, err});
    check({tag, " valid"}, {15'h0, out_valid}, {15'h0, v});
    check({tag, " sub"},   {15'h0, sub_mode},  {15'h0, s});
  endtask

  initial begin
    vecs[0] = '{4'h4, 1'b0, 8'h40, 8'h00, 3'd1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{4'h2, 1'b0, 8'h42, 8'h00, 3'd2, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{4'hA, 1'b0, 8'h42, 8'h00, 3'd2, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{4'h1, 1'b0, 8'h42, 8'h10, 3'd3, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{4'h7, 1'b1, 8'h42, 8'h17, 3'd4, 1'b0, 1'b1, 1'b1};

    rst_n = 1'b0;
    key_enter = 1'b1;
    key_clear = 1'b1;
    digit = 4'h0;
    op_sub = 1'b0;
    out_ready = 1'b0;
    #12;
    check_all("reset", 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(2);

    // entry sequence including a non-BCD digit in R_HI
    for (int i = 0; i < 5; i++) begin
      press(vecs[i].digit, vecs[i].op, 1'b1, 1'b0);
      check_all($sformatf("vec%0d", i), vecs[i].left, vecs[i].right, vecs[i].st,
                vecs[i].err, vecs[i].valid, vecs[i].sub);
    end

    // hold without ready, then a single-cycle ready
    op_sub = 1'b0;
    step(10);
    check_all("hold", 8'h42, 8'h17, 3'd4, 1'b0, 1'b1, 1'b1);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    check_all("xfer", 8'h42, 8'h17, 3'd0, 1'b0, 1'b0, 1'b1);

    // glitch rejection, with ready asserted while not valid
    out_ready = 1'b1;
    digit = 4'h5;
    key_enter = 1'b0;
    step(2);
    key_enter = 1'b1;
    step(12);
    check("glitch state", {13'h0, entry_state}, 16'd0);
    check("ready idle valid", {15'h0, out_valid}, 16'd0);
    for (int c = 0; c < 12; c++) begin
      key_enter = (c == 2 || c == 4) ? 1'b1 : 1'b0;
      step(1);
    end
    key_enter = 1'b1;
    step(12);
    out_ready = 1'b0;
    check("bouncy state", {13'h0, entry_state}, 16'd1);
    check("bouncy left", {8'h00, left_bcd}, 16'h0052);

    // complete, then frozen in DONE
    press(4'h3, 1'b0, 1'b1, 1'b0);
    press(4'h8, 1'b0, 1'b1, 1'b0);
    press(4'h6, 1'b0, 1'b1, 1'b0);
    check_all("done", 8'h53, 8'h86, 3'd4, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      press(4'h1, ~op_sub, 1'b1, 1'b0);
    end
    check_all("frozen", 8'h53, 8'h86, 3'd4, 1'b0, 1'b1, 1'b0);

    // clear pulse lands on the same edge as a transfer
    key_clear = 1'b0;
    step(DB + 2);
    check("pre-clear valid", {15'h0, out_valid}, 16'd1);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    check_all("clr+xfer", 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    key_clear = 1'b1;
    step(DB + 4);

    // clear and enter together in R_LO
    press(4'h1, 1'b0, 1'b1, 1'b0);
    press(4'h2, 1'b0, 1'b1, 1'b0);
    press(4'h3, 1'b0, 1'b1, 1'b0);
    check("rlo state", {13'h0, entry_state}, 16'd3);
    press(4'h4, 1'b0, 1'b1, 1'b1);
    check_all("clr+enter", 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);

    // asynchronous reset mid-cycle in DONE
    press(4'h9, 1'b0, 1'b1, 1'b0);
    press(4'h9, 1'b0, 1'b1, 1'b0);
    press(4'h0, 1'b0, 1'b1, 1'b0);
    press(4'h1, 1'b1, 1'b1, 1'b0);
    check_all("pre-rst", 8'h99, 8'h01, 3'd4, 1'b0, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async rst", 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    step(2);
    rst_n = 1'b1;
    step(2);
    press(4'h7, 1'b0, 1'b1, 1'b0);
    check_all("post-rst", 8'h70, 8'h00, 3'd1, 1'b0, 1'b0, 1'b0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bcd_operand_entry.md
Name: bcd_operand_entry

Overview:
Upstream stage of the BCD add/subtract calculator. Collects two 2-digit BCD operands one digit at a time from four switches and a debounced push-button, plus an add/subtract select. Presents them as stable, validated operand words with a valid/ready handshake. The calculator stage combinationally consumes LEFT_BCD, RIGHT_BCD and SUB_MODE. Its LED/HEX logic may use ENTRY_STATE and DIGIT_ERR.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a button level change (10 ms at 50 MHz); must be >= 1

Ports:
CLOCK_50  in  1  system clock, all state on rising edge
RST_N  in  1  asynchronous active-low reset
KEY_ENTER  in  1  raw push-button, active-low (pressed = 0), asynchronous to CLOCK_50
KEY_CLEAR  in  1  raw push-button, active-low, asynchronous
DIGIT  in  4  candidate BCD digit from switches
OP_SUB  in  1  mode select: 1 = subtract, 0 = add
OUT_READY  in  1  downstream accepts current operands
LEFT_BCD  out  8  left operand {tens, ones}
RIGHT_BCD  out  8  right operand {tens, ones}
SUB_MODE  out  1  latched OP_SUB
OUT_VALID  out  1  operands complete and stable
ENTRY_STATE  out  3  current FSM state encoding
DIGIT_ERR  out  1  last enter attempt carried a non-BCD digit

Behaviour:
- Reset (RST_N = 0, takes effect immediately, no clock needed):
  - LEFT_BCD, RIGHT_BCD = 8'h00; SUB_MODE, OUT_VALID, DIGIT_ERR = 0.
  - State = L_HI.
  - Debounced levels = 1 (released); synchronisers = 1; counters = 0.
- Button path, per key:
  - 2-flop synchroniser, then debouncer.
  - Debouncer counter clears whenever the synchronised input equals the debounced level; otherwise it increments.
  - On reaching DEBOUNCE_CYCLES-1 the debounced level flips and the counter clears.
  - A press event is a one-cycle pulse on a debounced 1->0 transition. Releases generate nothing.
- Latency: press-to-pulse = 2 sync cycles + DEBOUNCE_CYCLES. State and outputs update on the edge after the pulse.
- FSM states: L_HI(0), L_LO(1), R_HI(2), R_LO(3), DONE(4). Encodings 5-7 unused; recover to L_HI.
- Enter pulse in L_HI..R_LO with DIGIT <= 9:
  - Write DIGIT into the corresponding nibble (L_HI -> LEFT_BCD[7:4], L_LO -> [3:0], R_HI -> RIGHT_BCD[7:4], R_LO -> [3:0]).
  - Clear DIGIT_ERR and advance one state.
- Enter pulse in R_LO (valid digit): also latch OP_SUB into SUB_MODE and go to DONE. OUT_VALID = 1 from that same edge.
- Enter pulse with DIGIT > 9: no write, no advance, DIGIT_ERR = 1 (sticky until the next valid enter, clear, or reset).
- DONE state:
  - OUT_VALID held 1.
  - LEFT_BCD, RIGHT_BCD and SUB_MODE frozen; enter pulses and OP_SUB changes ignored.
  - Transfer occurs on any edge with OUT_VALID & OUT_READY: next cycle OUT_VALID = 0 and state = L_HI.
  - Operand registers keep their values until overwritten digit by digit.
- OUT_READY while OUT_VALID = 0 has no effect.
- Clear pulse, any state: state L_HI; LEFT_BCD, RIGHT_BCD = 0; SUB_MODE, OUT_VALID, DIGIT_ERR = 0.
- Simultaneous events:
  - Clear and enter pulses in the same cycle: clear wins, enter discarded.
  - Clear coincident with a transfer: the transfer counts as completed (consumer sampled it) and the clear is applied.
- Outputs are registered; no combinational path from inputs to outputs.
- Output invariant: every nibble of LEFT_BCD and RIGHT_BCD is always 0-9.

Decomposition:
- Shared package:
  - state encodings L_HI..DONE and ST_W = 3;
  - BCD_MAX = 4'd9;
  - released-level constant KEY_UP = 1'b1.
- Sub-module key_debounce (parameter DEBOUNCE_CYCLES; ports CLOCK_50, RST_N, key_n, press_pulse).
  - Contains the synchroniser, counter of width $clog2(DEBOUNCE_CYCLES+1), and edge detector.
  - Instantiated twice, for KEY_ENTER and KEY_CLEAR.

Test Plan:
(Run with DEBOUNCE_CYCLES = 4.)
1. Enter digits 4,2,1,7 with OP_SUB = 1 at the last press -> LEFT_BCD = 8'h42, RIGHT_BCD = 8'h17, SUB_MODE = 1, OUT_VALID = 1. Hold OUT_READY = 0 for 10 cycles -> all unchanged. Pulse OUT_READY -> OUT_VALID = 0 next cycle, ENTRY_STATE = 0, operands still 8'h42/8'h17.
2. In R_HI, DIGIT = 4'hA + enter -> DIGIT_ERR = 1, ENTRY_STATE stays 2, RIGHT_BCD unchanged. Then DIGIT = 3 + enter -> RIGHT_BCD[7:4] = 3, DIGIT_ERR = 0, ENTRY_STATE = 3.
3. KEY_ENTER low for 2 cycles (glitch) -> no state change. Low for 12 cycles with 1-cycle high blips at cycles 3 and 5, then released -> exactly one advance.
4. In DONE, toggle OP_SUB and press enter three times -> SUB_MODE and operands unchanged, OUT_VALID stays 1.
5. In R_LO, clear and enter debounced in the same cycle -> ENTRY_STATE = 0, both operands 8'h00, OUT_VALID = 0. Also: clear coincident with OUT_VALID & OUT_READY -> ends in L_HI with zeroed outputs.
6. Assert RST_N = 0 mid-cycle while in DONE with operands 8'h99/8'h01 -> all outputs 0 and ENTRY_STATE = 0 before the next clock edge. Release -> first valid enter writes LEFT_BCD[7:4].
